// File: rtl/axil_pkg.sv
// Shared constants and helpers for the AXI-Lite register file.
// Response codes, address-LSB and index-width helpers.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int addr_lsb(input int dw);
    return $clog2(dw / 8);
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axil_hold_buf.sv
// One-entry holding register for a valid/ready channel.
// Ports: clk, rst_n, in_valid/in_data/in_ready, take (consume), full, data.
module axil_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             take,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic hs;
  logic full_nx;

  assign hs = in_valid & in_ready;

  // take drains the held entry if any, else the incoming beat
  assign full_nx = full ? ~take : (hs & ~take);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      in_ready <= 1'b0;
      data     <= '0;
    end else begin
      full     <= full_nx;
      in_ready <= ~full_nx;
      if (!full && hs && !take)
        data <= in_data;
    end
  end

endmodule

// File: rtl/axil_regfile.sv
// AXI4-Lite register file: NUM_REGS regs, byte strobes, buffered AW/W.
// Option AXIL_REGFILE_ERR_RESP_EN: SLVERR for out-of-range indices.
module axil_regfile
  import axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 7,
  parameter int NUM_REGS           = 32
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] o_regs,
  output logic [NUM_REGS-1:0]           o_wr_pulse
);

  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int AW  = C_S_AXI_ADDR_WIDTH;
  localparam int SW  = DW / 8;
  localparam int LSB = addr_lsb(DW);
  localparam int FIW = AW - LSB;
  localparam int IW  = idx_w(NUM_REGS);
  localparam logic [FIW:0] NREG_F = (FIW+1)'(NUM_REGS);
  localparam logic [IW:0]  NREG_I = (IW+1)'(NUM_REGS);
`ifdef AXIL_REGFILE_ERR_RESP_EN
  localparam logic [1:0] ERR_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] ERR_RESP = RESP_OKAY;
`endif

  logic [DW-1:0]    regs [NUM_REGS];
  logic             aw_full;
  logic             w_full;
  logic [AW-1:0]    aw_q;
  logic [DW+SW-1:0] w_q;
  logic             aw_hs;
  logic             w_hs;
  logic             fire;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [SW-1:0]    wr_strb;
  logic [FIW-1:0]   w_fidx;
  logic [FIW-1:0]   r_fidx;
  logic [IW-1:0]    w_idx;
  logic [IW-1:0]    r_idx;
  logic             w_ok;
  logic             r_ok;
  logic             ar_hs;
  logic             unused_ok;

  axil_hold_buf #(.WIDTH(AW)) u_aw_buf (
    .clk      (S_AXI_ACLK),
    .rst_n    (S_AXI_ARESETN),
    .in_valid (S_AXI_AWVALID),
    .in_data  (S_AXI_AWADDR),
    .in_ready (S_AXI_AWREADY),
    .take     (fire),
    .full     (aw_full),
    .data     (aw_q)
  );

  axil_hold_buf #(.WIDTH(DW+SW)) u_w_buf (
    .clk      (S_AXI_ACLK),
    .rst_n    (S_AXI_ARESETN),
    .in_valid (S_AXI_WVALID),
    .in_data  ({S_AXI_WDATA, S_AXI_WSTRB}),
    .in_ready (S_AXI_WREADY),
    .take     (fire),
    .full     (w_full),
    .data     (w_q)
  );

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign fire  = (aw_full | aw_hs) & (w_full | w_hs)
               & (~S_AXI_BVALID | S_AXI_BREADY);

  assign wr_addr = aw_full ? aw_q : S_AXI_AWADDR;
  assign {wr_data, wr_strb} = w_full ? w_q
                            : {S_AXI_WDATA, S_AXI_WSTRB};

  assign w_fidx = wr_addr[AW-1:LSB];
  assign r_fidx = S_AXI_ARADDR[AW-1:LSB];
  assign w_idx  = w_fidx[IW-1:0];
  assign r_idx  = r_fidx[IW-1:0];

`ifdef AXIL_REGFILE_ERR_RESP_EN
  assign w_ok = {1'b0, w_fidx} < NREG_F;
  assign r_ok = {1'b0, r_fidx} < NREG_F;
`else
  assign w_ok = {1'b0, w_idx} < NREG_I;
  assign r_ok = {1'b0, r_idx} < NREG_I;
`endif

  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
  assign S_AXI_ARREADY = ~S_AXI_RVALID | S_AXI_RREADY;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       wr_addr, S_AXI_ARADDR,
                       w_fidx, r_fidx, NREG_F, NREG_I};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      o_wr_pulse   <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
    end else begin
      o_wr_pulse <= '0;
      if (fire) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= w_ok ? RESP_OKAY : ERR_RESP;
        if (w_ok) begin
          o_wr_pulse[w_idx] <= 1'b1;
          for (int b = 0; b < SW; b++)
            if (wr_strb[b])
              regs[w_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end else if (S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  // Reads sample regs before this edge's write lands
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= r_ok ? regs[r_idx] : '0;
      S_AXI_RRESP  <= r_ok ? RESP_OKAY : ERR_RESP;
    end else if (S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign o_regs[g*DW +: DW] = regs[g];
  end

endmodule

// File: tb/tb_axil_regfile.sv
// Directed self-checking bench for axil_regfile (NUM_REGS=20).
// Drives and samples on the falling clock edge.
module tb_axil_regfile;

  localparam int NR = 20;
`ifdef AXIL_REGFILE_ERR_RESP_EN
  localparam logic [1:0] EXP_ERR = 2'b10;
`else
  localparam logic [1:0] EXP_ERR = 2'b00;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [6:0]    araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic [NR*32-1:0] o_regs;
  logic [NR-1:0] o_wr_pulse;

  int n_cmp = 0;
  int n_err = 0;
  int b_hs  = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && bvalid && bready) b_hs++;

  axil_regfile #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (7),
    .NUM_REGS           (NR)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .o_regs        (o_regs),
    .o_wr_pulse    (o_wr_pulse)
  );

  function automatic logic [31:0] reg_at(input int i);
    return o_regs[i*32 +: 32];
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [6:0] a,
                           input logic [31:0] d,
                           input logic [3:0] s,
                           output logic [1:0] resp,
                           output logic [NR-1:0] pulse);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
      logic ah, wh;
      ah = awvalid && awready;
      wh = wvalid && wready;
      @(negedge clk);
      if (ah) awvalid = 1'b0;
      if (wh) wvalid = 1'b0;
    end
    check("wr_accept", {awvalid, wvalid}, 0);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 20 && !bvalid; i++) @(negedge clk);
    check("wr_bvalid", bvalid, 1);
    resp = bresp;
    pulse = o_wr_pulse;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [6:0] a,
                          output logic [31:0] d,
                          output logic [1:0] resp);
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 20 && !arready; i++) @(negedge clk);
    check("rd_arready", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    for (int i = 0; i < 20 && !rvalid; i++) @(negedge clk);
    check("rd_rvalid", rvalid, 1);
    d = rdata;
    resp = rresp;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0]     mdl [NR];
    logic [31:0]     rd;
    logic [1:0]      rs;
    logic [NR-1:0]   pl;
    logic [NR*32-1:0] snap;
    logic [31:0]     expr;
    int              h0;
    int              wi, ri;

    rst_n = 1'b0;
    awaddr = '0; awprot = 3'b010; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    araddr = '0; arprot = 3'b001; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    for (int i = 0; i < NR; i++) mdl[i] = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_regs_zero", o_regs == '0, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_awready", awready, 1);
    check("rel_wready", wready, 1);

    // write with BREADY low, second pair buffered
    bready = 1'b0;
    h0 = b_hs;
    awaddr = 7'h40; wdata = 32'h8000_0000; wstrb = 4'b1000;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    check("a_bvalid", bvalid, 1);
    check("a_bresp", bresp, 0);
    check("a_reg16", reg_at(16), 32'h8000_0000);
    check("a_pulse16", o_wr_pulse, 20'h1 << 16);
    awaddr = 7'h44; wdata = 32'hA5A5_A5A5; wstrb = 4'hF;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("a_awready_drop", awready, 0);
    check("a_wready_drop", wready, 0);
    check("a_bvalid_hold1", bvalid, 1);
    check("a_reg17_pending", reg_at(17), 0);
    @(negedge clk);
    check("a_bvalid_hold2", bvalid, 1);
    @(negedge clk);
    check("a_bvalid_hold3", bvalid, 1);
    check("a_hs_none", b_hs - h0, 0);
    bready = 1'b1;
    @(negedge clk);
    check("a_reg17", reg_at(17), 32'hA5A5_A5A5);
    check("a_bvalid_2nd", bvalid, 1);
    check("a_pulse17", o_wr_pulse, 20'h1 << 17);
    check("a_awready_back", awready, 1);
    @(negedge clk);
    check("a_bvalid_done", bvalid, 0);
    check("a_hs_count", b_hs - h0, 2);
    mdl[16] = 32'h8000_0000;
    mdl[17] = 32'hA5A5_A5A5;

    // read stalled by RREADY low, same-cycle write to same reg
    rready = 1'b0;
    araddr = 7'h40; arvalid = 1'b1;
    awaddr = 7'h40; wdata = 32'h1111_1111; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check("b_rvalid", rvalid, 1);
    check("b_rdata_old", rdata, 32'h8000_0000);
    check("b_reg16_new", reg_at(16), 32'h1111_1111);
    @(negedge clk);
    @(negedge clk);
    check("b_rdata_stable", rdata, 32'h8000_0000);
    check("b_rvalid_hold", rvalid, 1);
    check("b_arready_low", arready, 0);
    rready = 1'b1;
    @(negedge clk);
    check("b_rvalid_clr", rvalid, 0);
    mdl[16] = 32'h1111_1111;

    // AW first, W five cycles later, partial strobes
    h0 = b_hs;
    awaddr = 7'h08; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("c_aw_buffered", awready, 0);
    repeat (4) @(negedge clk);
    check("c_no_b", bvalid, 0);
    check("c_reg2_pending", reg_at(2), 0);
    wdata = 32'h1234_5678; wstrb = 4'b0101; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("c_bvalid", bvalid, 1);
    check("c_pulse2", o_wr_pulse, 20'h1 << 2);
    check("c_reg2", reg_at(2), 32'h0034_0078);
    @(negedge clk);
    check("c_pulse_once", o_wr_pulse, 0);
    check("c_bvalid_clr", bvalid, 0);
    check("c_one_b", b_hs - h0, 1);
    check("c_awready", awready, 1);
    mdl[2] = 32'h0034_0078;

    // back-to-back traffic with both ready held high
    for (int i = 0; i < 32; i++) begin
      wi = 4 + (i % 8);
      ri = 4 + ((i + 7) % 8);
      awaddr = 7'(wi * 4);
      wdata = 32'hC0DE_0000 + 32'(i);
      wstrb = 4'hF;
      araddr = 7'(ri * 4);
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      expr = mdl[ri];
      mdl[wi] = wdata;
      @(negedge clk);
      check("d_bvalid", bvalid, 1);
      check("d_rvalid", rvalid, 1);
      check("d_rdata", rdata, expr);
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("d_bvalid_end", bvalid, 0);
    check("d_rvalid_end", rvalid, 0);
    for (int i = 0; i < NR; i++)
      check("d_reg_model", reg_at(i), mdl[i]);

    // out-of-range index 25
    snap = o_regs;
    axi_write(7'h64, 32'hDEAD_BEEF, 4'hF, rs, pl);
    check("e_bresp", rs, EXP_ERR);
    check("e_no_pulse", pl, 0);
    check("e_regs_same", o_regs === snap, 1);
    axi_read(7'h64, rd, rs);
    check("e_rdata", rd, 0);
    check("e_rresp", rs, EXP_ERR);
    axi_read(7'h48, rd, rs);
    check("e_reg18_rd", rd, 0);
    axi_read(7'h44, rd, rs);
    check("e_reg17_rd", rd, 32'hA5A5_A5A5);
    check("e_reg17_resp", rs, 0);

    // async reset while RVALID pending
    rready = 1'b0;
    araddr = 7'h40; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    check("f_rvalid", rvalid, 1);
    check("f_rdata", rdata, 32'h1111_1111);
    #2 rst_n = 1'b0;
    #1;
    check("f_rvalid_async", rvalid, 0);
    check("f_awready_rst", awready, 0);
    check("f_regs_clr", o_regs == '0, 1);
    rready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("f_awready_rel", awready, 1);
    axi_read(7'h40, rd, rs);
    check("f_rd_cleared", rd, 0);
    check("f_rd_resp", rs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axil_regfile.md
# axil_regfile

Parametrised AXI4-Lite slave register file, the next generation of our demo AXI-Lite peripheral. It provides NUM_REGS software-visible registers behind a fully protocol-compliant AXI-Lite slave port, with per-byte write strobes and independent AW/W acceptance. B and R backpressure are handled correctly: no response is dropped or overwritten while BREADY/RREADY is low. It sits behind the interconnect as a generic control/status register block.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; 32 or 64.
- C_S_AXI_ADDR_WIDTH, 7: byte address width.
- NUM_REGS, 32: register count; 1..2^(C_S_AXI_ADDR_WIDTH-ADDR_LSB); ADDR_LSB = log2(C_S_AXI_DATA_WIDTH/8).
- S_AXI_ACLK  in  1  clock; all logic on its rising edge.
- S_AXI_ARESETN  in  1  reset; asynchronous, active-low.
- S_AXI_AWADDR/AWPROT/AWVALID  in  ADDR_W/3/1; S_AXI_AWREADY  out  1.
- S_AXI_WDATA/WSTRB/WVALID  in  DATA_W/DATA_W/8/1; S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1.
- S_AXI_ARADDR/ARPROT/ARVALID  in  ADDR_W/3/1; S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  DATA_W; S_AXI_RRESP  out  2; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1.
- o_regs  out  NUM_REGS*DATA_W  flat register contents, reg i at [i*DATA_W +: DATA_W].
- o_wr_pulse  out  NUM_REGS  one-cycle pulse, bit i set the cycle after reg i is written.

## Operation
- Register index = addr[ADDR_W-1:ADDR_LSB]; low ADDR_LSB bits and PROT ignored.
- AW and W channels each have a one-entry holding buffer. AWREADY = !aw_full, WREADY = !w_full (both registered).
- Address available = aw_full or AW handshake this cycle; data likewise. Write fires when both are available and the B slot is free (!BVALID or BREADY).
- A fire consumes the buffered entry, or the incoming beat directly with no buffering. A beat accepted without a fire fills its buffer.
- On fire: each byte lane with WSTRB set is updated. BVALID is set next cycle with BRESP; o_wr_pulse[idx] is set next cycle.
- BVALID holds, and BRESP is stable, until BREADY.
- Read: ARREADY = !RVALID or RREADY (combinational from RREADY, permitted by the protocol). On AR handshake, RDATA/RRESP register next cycle and RVALID is set.
- RVALID/RDATA/RRESP are held stable until RREADY.
- Simultaneous read and write to the same register in one cycle: the read returns the pre-write value.
- Reset (async assert): all registers 0; buffers empty; AWREADY=WREADY=0 while reset is asserted, 1 in the first cycle after release. All other outputs 0. Reset mid-transaction discards all pending beats and responses.

## Timing
- Write latency: AW+W accepted in cycle N produces BVALID in N+1.
- Read latency: AR accepted in cycle N produces RVALID in N+1.
- Throughput: one write and one read per cycle when BREADY/RREADY are held high.
- With BREADY low: at most one outstanding B. Further AW/W beats fill their buffers, after which AWREADY/WREADY deassert the following cycle.
- AW without W, or W without AW, is buffered indefinitely; no timeout.

## Configuration
- AXIL_REGFILE_ERR_RESP_EN defined: an index >= NUM_REGS gives BRESP/RRESP = SLVERR (2'b10); the write is dropped and RDATA=0.
- Not defined: all responses OKAY. The index is truncated to clog2(NUM_REGS) bits. Remaining out-of-range indices read 0 and ignore writes. No o_wr_pulse is generated for ignored writes.

## Structure
- Package axil_pkg holds: RESP_OKAY=2'b00 and RESP_SLVERR=2'b10; the ADDR_LSB computation function; the index-width clog2 helper.
- Sub-module axil_hold_buf: one-entry valid/ready holding register, parameter WIDTH. It is instantiated for AW (addr) and W (data+strb).
- Register array, decode, and B/R logic live in the top.

## Test plan
- Reset, then AW+W together at 0x40 with WDATA=0x8000_0000, WSTRB=4'b1000, BREADY=0 for 4 cycles. Required:
  - reg16 = 0x8000_0000 and BVALID=1 from the next cycle, held.
  - A second AW/W pair is buffered, then AWREADY/WREADY drop.
  - On BREADY=1, the second B follows; exactly two B handshakes in total.
- AR at 0x40 with RREADY=0 for 3 cycles while a write to 0x40 occurs -> RDATA stable at the pre-write value until RREADY.
- AW at 0x08, then W (0x1234_5678, WSTRB=4'b0101) 5 cycles later -> reg2 = 0x0034_0078, one B, o_wr_pulse[2] a single cycle.
- Back-to-back writes and reads with BREADY=RREADY=1 for 32 cycles -> one B and one R per cycle, data matches a scoreboard.
- NUM_REGS=20, access index 25: with the macro -> SLVERR and RDATA=0; without the macro -> OKAY and RDATA=0; registers unchanged in both cases.
- Assert ARESETN mid-read with RVALID=1 -> RVALID=0 immediately (async); the next read returns 0 from the cleared register.
